// File: rtl/core_pkg.sv
// Definitions shared across the core: register-index width and the EX operand
// forwarding-mux select encoding, which the hazard unit and the mux must agree on.
package core_pkg;
    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping, so a long run
// never reports a misleadingly small count.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32I pipeline: EX operand forwarding,
// load-use stall, branch flush, plus stall/flush event counters.
module hazard_unit #(
    parameter int REG_ADDR_W = core_pkg::REG_ADDR_W,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic                  RegWriteE,
    input  logic                  LoadE,
    input  logic                  PCSrcE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [CNT_WIDTH-1:0]  StallCount,
    output logic [CNT_WIDTH-1:0]  FlushCount
);
    import core_pkg::FWD_RF;
    import core_pkg::FWD_WB;
    import core_pkg::FWD_MEM;

    logic [REG_ADDR_W-1:0] rd_m_q, rd_m_d;
    logic [REG_ADDR_W-1:0] rd_w_q, rd_w_d;
    logic                  reg_write_m_q, reg_write_m_d;
    logic                  reg_write_w_q, reg_write_w_d;

    // EX/MEM and MEM/WB never stall, so the shadow copies simply shift every cycle.
    always_comb begin
        rd_m_d        = RdE;
        reg_write_m_d = RegWriteE;
        rd_w_d        = rd_m_q;
        reg_write_w_d = reg_write_m_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_m_q        <= '0;
            rd_w_q        <= '0;
            reg_write_m_q <= 1'b0;
            reg_write_w_q <= 1'b0;
        end else begin
            rd_m_q        <= rd_m_d;
            rd_w_q        <= rd_w_d;
            reg_write_m_q <= reg_write_m_d;
            reg_write_w_q <= reg_write_w_d;
        end
    end

    logic [REG_ADDR_W-1:0] rs_e [2];
    logic [1:0]            fwd_sel [2];
    logic                  mem_hit [2];
    logic                  wb_hit  [2];

    assign rs_e[0] = Rs1E;
    assign rs_e[1] = Rs2E;

    // MEM is checked first because it holds the newer value; x0 is never forwarded.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign mem_hit[gi] = reg_write_m_q && (rd_m_q != '0) && (rd_m_q == rs_e[gi]);
        assign wb_hit[gi]  = reg_write_w_q && (rd_w_q != '0) && (rd_w_q == rs_e[gi]);
        assign fwd_sel[gi] = mem_hit[gi] ? FWD_MEM : (wb_hit[gi] ? FWD_WB : FWD_RF);
    end

    logic lw_stall;

    // A taken branch squashes the dependent instruction, so it suppresses the stall.
    assign lw_stall = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;

    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        if (!reset) begin
            ForwardAE = fwd_sel[0];
            ForwardBE = fwd_sel[1];
            StallF    = lw_stall;
            StallD    = lw_stall;
            FlushD    = PCSrcE;
            FlushE    = lw_stall || PCSrcE;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (lw_stall),
        .count (StallCount)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (PCSrcE),
        .count (FlushCount)
    );
endmodule
